lcd_scanout: RTL

//  Downstream consumer of the SDRAM frame reader's pixel FIFO. Generates LCD raster timing
//  (HSYNC/VSYNC/DE), pops one show-ahead FIFO word per active pixel and drives RGB565 to the panel.

---
 rtl/lcd_scanout_pkg.sv | 47 ++++
 rtl/lcd_scanout_sync_gen.sv | 56 +++++
 rtl/lcd_scanout.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/lcd_scanout_pkg.sv
// Shared definitions for the LCD scan-out block: default panel timing, FSM state
// encodings, RGB565 field positions, raster flag bundle and the colour-bar palette.
package lcd_scanout_pkg;

  localparam int H_ACTIVE_DEF = 480;
  localparam int H_FP_DEF     = 8;
  localparam int H_SYNC_DEF   = 4;
  localparam int H_BP_DEF     = 43;
  localparam int V_ACTIVE_DEF = 200;
  localparam int V_FP_DEF     = 8;
  localparam int V_SYNC_DEF   = 4;
  localparam int V_BP_DEF     = 12;

  localparam logic [0:0] ST_WAIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam int R_MSB = 15;
  localparam int R_LSB = 11;
  localparam int G_MSB = 10;
  localparam int G_LSB = 5;
  localparam int B_MSB = 4;
  localparam int B_LSB = 0;

  // Raster position flags decoded from the h/v counters (all active-high).
  typedef struct packed {
    logic active;
    logic hsync;
    logic vsync;
  } raster_t;

  // Eight vertical bars, left to right: white, yellow, cyan, green, magenta, red, blue, black.
  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = 16'hFFFF;
      3'd1:    c = 16'hFFE0;
      3'd2:    c = 16'h07FF;
      3'd3:    c = 16'h07E0;
      3'd4:    c = 16'hF81F;
      3'd5:    c = 16'hF800;
      3'd6:    c = 16'h001F;
      default: c = 16'h0000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/lcd_scanout_sync_gen.sv
// Horizontal/vertical raster counters with decoded active/hsync/vsync flags.
// Counters hold at the frame origin (0,0) while en is low.
module lcd_scanout_sync_gen
  import lcd_scanout_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic [HW-1:0] h,
  output logic [VW-1:0] v,
  output raster_t       flags
);

  logic h_last;
  logic v_last;

  assign h_last = (h == HW'(H_TOTAL - 1));
  assign v_last = (v == VW'(V_TOTAL - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h <= '0;
      v <= '0;
    end else if (!en) begin
      h <= '0;
      v <= '0;
    end else if (h_last) begin
      h <= '0;
      v <= v_last ? '0 : v + 1'b1;
    end else begin
      h <= h + 1'b1;
    end
  end

  // Sync windows sit between the front and back porches of each axis.
  always_comb begin
    flags        = '0;
    flags.active = (h < HW'(H_ACTIVE)) && (v < VW'(V_ACTIVE));
    flags.hsync  = (h >= HW'(H_ACTIVE + H_FP)) && (h < HW'(H_ACTIVE + H_FP + H_SYNC));
    flags.vsync  = (v >= VW'(V_ACTIVE + V_FP)) && (v < VW'(V_ACTIVE + V_FP + V_SYNC));
  end

endmodule

// File: rtl/lcd_scanout.sv
// LCD raster scan-out: waits for the frame reader's first burst, then pops one FIFO word
// per active pixel and drives registered RGB565/HSync/VSync/DE. Optional LCD_TEST_PATTERN_EN.
module lcd_scanout
  import lcd_scanout_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL)
) (
  input  logic          i_Clk,
  input  logic          i_Reset_n,
  input  logic          i_First_Data_Ready,
  input  logic [15:0]   i_Pixel_Data,
  input  logic          i_Pixel_Empty,
`ifdef LCD_TEST_PATTERN_EN
  input  logic          i_Pattern_Sel,
`endif
  output logic          o_Pixel_Rd,
  output logic          o_LCD_HSync,
  output logic          o_LCD_VSync,
  output logic          o_LCD_DE,
  output logic [4:0]    o_LCD_R,
  output logic [5:0]    o_LCD_G,
  output logic [4:0]    o_LCD_B,
  output logic          o_Underflow,
  output logic          o_Dbg_State,
  output logic [HW-1:0] o_Dbg_H,
  output logic [VW-1:0] o_Dbg_V
);

  logic [0:0]    state;
  logic          run;
  logic          active_px;
  logic          pop;
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  raster_t       flags;
  logic [15:0]   pix_next;
  logic [15:0]   pix_q;
  logic          hsync_q;
  logic          vsync_q;
  logic          de_q;
  logic          underflow_q;

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state <= ST_WAIT;
    end else if (state == ST_WAIT && i_First_Data_Ready) begin
      state <= ST_RUN;
    end
  end

  assign run = (state == ST_RUN);

  lcd_scanout_sync_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_sync (
    .clk   (i_Clk),
    .rst_n (i_Reset_n),
    .en    (run),
    .h     (h),
    .v     (v),
    .flags (flags)
  );

  // FIFO handshake: !i_Pixel_Empty is valid for the show-ahead head word, o_Pixel_Rd is the
  // pop; a word transfers on any rising edge where both are high, and the word is consumed.
  // The raster never waits for data, so an empty FIFO on an active pixel is an underflow.
  assign active_px  = run && flags.active;
  assign pop        = active_px && !i_Pixel_Empty;
  assign o_Pixel_Rd = pop;

`ifdef LCD_TEST_PATTERN_EN
  localparam int HPW = HW + 3;
  logic [2:0] bar_idx;

  // bar = floor(h*8/H_ACTIVE), found by counting the bar boundaries already passed.
  always_comb begin
    bar_idx = '0;
    for (int k = 1; k < 8; k++) begin
      if ({h, 3'b000} >= HPW'(k * H_ACTIVE)) bar_idx = bar_idx + 3'd1;
    end
  end

  always_comb begin
    pix_next = '0;
    if (active_px && i_Pattern_Sel) pix_next = bar_color(bar_idx);
    else if (pop) pix_next = i_Pixel_Data;
  end
`else
  always_comb begin
    pix_next = '0;
    if (pop) pix_next = i_Pixel_Data;
  end
`endif

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
      de_q        <= 1'b0;
      pix_q       <= '0;
      underflow_q <= 1'b0;
    end else begin
      hsync_q <= !(run && flags.hsync);
      vsync_q <= !(run && flags.vsync);
      de_q    <= active_px;
      pix_q   <= pix_next;
      if (active_px && i_Pixel_Empty) underflow_q <= 1'b1;
    end
  end

  assign o_LCD_HSync = hsync_q;
  assign o_LCD_VSync = vsync_q;
  assign o_LCD_DE    = de_q;
  assign o_LCD_R     = pix_q[R_MSB:R_LSB];
  assign o_LCD_G     = pix_q[G_MSB:G_LSB];
  assign o_LCD_B     = pix_q[B_MSB:B_LSB];
  assign o_Underflow = underflow_q;
  assign o_Dbg_State = state;
  assign o_Dbg_H     = h;
  assign o_Dbg_V     = v;

endmodule
